// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store sequencer for a word-only data
// memory (combinational read, synchronous write). It handles byte and
// halfword access with sub-word read-modify-write, and it aligns and extends
// load data. Misaligned or illegal requests are answered with an error and
// never reach memory.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STW, S_RMW_RD, S_RMW_WR, S_ERR, S_RESP
  } state_t;

  state_t      state_q;
  logic [2:0]  a_funct3_q;
  logic [31:0] a_addr_q;
  logic [31:0] a_wdata_q;
  logic [31:0] m_q;           // old word captured for read-modify-write
  logic [31:0] r_q;           // staged response data, published in RESP
  logic        e_q;           // staged response error flag
  logic [31:0] wdata_q;       // last written word, held while not writing
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] merged;

  // Access legality: alignment by size, and which funct3 codes each
  // direction supports (unsigned variants exist only for loads).
  function automatic logic legal(input logic w, input logic [2:0] f3,
                                 input logic [1:0] lo);
    case (f3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = !lo[0];
      3'b010:  legal = (lo == 2'b00);
      3'b100:  legal = !w;
      3'b101:  legal = !w && !lo[0];
      default: legal = 1'b0;
    endcase
  endfunction

  // Pick the addressed lane out of a little-endian word and extend it.
  function automatic logic [31:0] ext(input logic [2:0] f3,
                                      input logic [1:0] lo,
                                      input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   ext = {{24{b[7] & !f3[2]}}, b};
      2'b01:   ext = {{16{h[15] & !f3[2]}}, h};
      default: ext = w;
    endcase
  endfunction

  // Replace the target byte/halfword of the old word with store data.
  always_comb begin
    merged = m_q;
    if (a_funct3_q[0]) begin
      if (a_addr_q[1]) merged[31:16] = a_wdata_q[15:0];
      else             merged[15:0]  = a_wdata_q[15:0];
    end else begin
      case (a_addr_q[1:0])
        2'd0:    merged[7:0]   = a_wdata_q[7:0];
        2'd1:    merged[15:8]  = a_wdata_q[7:0];
        2'd2:    merged[23:16] = a_wdata_q[7:0];
        default: merged[31:24] = a_wdata_q[7:0];
      endcase
    end
  end

  // Request FSM with registered response outputs. Address/data are only
  // latched for legal requests so the memory port holds across ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_funct3_q   <= '0;
      a_addr_q     <= '0;
      a_wdata_q    <= '0;
      m_q          <= '0;
      r_q          <= '0;
      e_q          <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          a_funct3_q <= req_funct3;
          if (!legal(req_write, req_funct3, req_addr[1:0])) begin
            state_q <= S_ERR;
          end else begin
            a_addr_q  <= req_addr;
            a_wdata_q <= req_wdata;
            if (!req_write)               state_q <= S_LOAD;
            else if (req_funct3 == 3'b010) state_q <= S_STW;
            else                           state_q <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          r_q     <= ext(a_funct3_q, a_addr_q[1:0], rdata);
          e_q     <= 1'b0;
          state_q <= S_RESP;
        end
        S_STW: begin
          wdata_q <= a_wdata_q;
          r_q     <= '0;
          e_q     <= 1'b0;
          state_q <= S_RESP;
        end
        S_RMW_RD: begin
          m_q     <= rdata;
          state_q <= S_RMW_WR;
        end
        S_RMW_WR: begin
          wdata_q <= merged;
          r_q     <= '0;
          e_q     <= 1'b0;
          state_q <= S_RESP;
        end
        S_ERR: begin
          r_q     <= '0;
          e_q     <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= r_q;
          resp_err_q   <= e_q;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory port decoded from state only; rst kills strobes at once so an
  // abort never lets a pending write land.
  always_comb begin
    memRead  = !rst && (state_q == S_LOAD || state_q == S_RMW_RD);
    memWrite = !rst && (state_q == S_STW  || state_q == S_RMW_WR);
    addr     = {a_addr_q[31:2], 2'b00};
    case (state_q)
      S_STW:    wdata = a_wdata_q;
      S_RMW_WR: wdata = merged;
      default:  wdata = wdata_q;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err, memRead, memWrite;
  logic [31:0] resp_rdata, addr, wdata, rdata;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .memRead(memRead), .memWrite(memWrite), .addr(addr), .wdata(wdata),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  // word memory: combinational read, write on rising edge; bench preload port
  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0, pre_data = '0;
  assign rdata = mem[addr[11:2]];
  always @(posedge clk) begin
    if (pre_we)        mem[pre_addr[11:2]] <= pre_data;
    else if (memWrite) mem[addr[11:2]]     <= wdata;
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // observations of the last request (cycle numbers: 1 = cycle after accept)
  int          o_rdn, o_wrn, o_respn, o_nrd, o_nwr;
  logic [31:0] o_rd, o_wd;
  logic        o_err, o_rdy;

  task automatic run_req(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    o_rdy = req_ready;
    req_valid = 1'b1; req_write = w; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_rdn = 0; o_wrn = 0; o_respn = 0; o_nrd = 0; o_nwr = 0;
    o_rd = 32'hx; o_wd = 32'hx; o_err = 1'bx;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (memRead)  begin o_nrd++; if (o_rdn == 0) o_rdn = n; end
      if (memWrite) begin o_nwr++; if (o_wrn == 0) o_wrn = n; o_wd = wdata; end
      if (resp_valid && o_respn == 0) begin
        o_respn = n; o_rd = resp_rdata; o_err = resp_err;
      end
    end
  endtask

  task automatic test_reset;
    logic [101:0] got;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {req_ready, resp_valid, resp_err, memRead, memWrite, 1'b0,
           resp_rdata, addr, wdata};
    n_tests++;
    if (got !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0", got);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset got %b exp 1", req_ready);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [8]  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010,
                              3'b000, 3'b001, 3'b100};
    logic [31:0] as  [8]  = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100,
                              32'h100, 32'h100, 32'h103};
    logic [31:0] exp [8]  = '{32'hFFFFFF99, 32'h00000099, 32'h00008899,
                              32'hFFFF8899, 32'h8899AABB, 32'hFFFFFFBB,
                              32'hFFFFAABB, 32'h00000088};
    logic [51:0] got, want;
    poke(32'h100, 32'h8899AABB);
    for (int i = 0; i < 8; i++) begin
      run_req(1'b0, f3s[i], as[i], 32'hFFFF_FFFF);
      got  = {o_rd, 3'b0, o_err, 4'(o_respn), 4'(o_rdn), 4'(o_nrd), 4'(o_nwr)};
      want = {exp[i], 4'h0, 4'd3, 4'd1, 4'd1, 4'd0};
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL load_%0d got %h exp %h", i, got, want);
      end
    end
  endtask

  task automatic test_errors;
    logic        ws  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] as  [4] = '{32'h103, 32'h101, 32'h100, 32'h100};
    logic [47:0] got, want;
    for (int i = 0; i < 4; i++) begin
      run_req(ws[i], f3s[i], as[i], 32'h5A5A5A5A);
      got  = {o_rd, 3'b0, o_err, 4'(o_respn), 4'(o_nrd), 4'(o_nwr)};
      want = {32'h0, 4'h1, 4'd3, 4'd0, 4'd0};
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL error_%0d got %h exp %h", i, got, want);
      end
    end
  endtask

  task automatic test_sub_store;
    logic [55:0] got, want;
    poke(32'h200, 32'h11223344);
    run_req(1'b1, 3'b000, 32'h201, 32'hDEADBEEF);
    got  = {o_wd, 3'b0, o_err, 4'(o_rdn), 4'(o_wrn), 4'(o_respn), 4'(o_nwr)};
    want = {32'h1122EF44, 4'h0, 4'd1, 4'd2, 4'd4, 4'd1};
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL sb_seq got %h exp %h", got, want);
    end
    n_tests++;
    if (o_rd !== 32'h0) begin
      n_fail++; $display("FAIL sb_rdata got %h exp 0", o_rd);
    end
    run_req(1'b0, 3'b010, 32'h200, 32'h0);
    n_tests++;
    if (o_rd !== 32'h1122EF44) begin
      n_fail++; $display("FAIL lw_after_sb got %h exp 1122ef44", o_rd);
    end
    poke(32'h200, 32'h11223344);
    run_req(1'b1, 3'b001, 32'h202, 32'h0000CAFE);
    n_tests++;
    if (mem[32'h200 >> 2] !== 32'hCAFE3344 || o_respn != 4) begin
      n_fail++;
      $display("FAIL sh_mem got %h/%0d exp cafe3344/4", mem[32'h200 >> 2], o_respn);
    end
    run_req(1'b1, 3'b000, 32'h203, 32'h00000055);
    n_tests++;
    if (mem[32'h200 >> 2] !== 32'h55FE3344) begin
      n_fail++; $display("FAIL sb_hi_mem got %h exp 55fe3344", mem[32'h200 >> 2]);
    end
  endtask

  task automatic test_word_store;
    logic [47:0] got, want;
    poke(32'h204, 32'hFFFFFFFF);
    run_req(1'b1, 3'b010, 32'h204, 32'h01234567);
    got  = {o_wd, 4'(o_nrd), 4'(o_nwr), 4'(o_wrn), 4'(o_respn)};
    want = {32'h01234567, 4'd0, 4'd1, 4'd1, 4'd3};
    n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL sw_seq got %h exp %h", got, want);
    end
    n_tests++;
    if (mem[32'h204 >> 2] !== 32'h01234567) begin
      n_fail++; $display("FAIL sw_mem got %h exp 01234567", mem[32'h204 >> 2]);
    end
  endtask

  task automatic test_reset_abort;
    int saw_resp = 0;
    poke(32'h300, 32'hAABBCCDD);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h301; req_wdata = 32'h11;
    @(posedge clk); #1;        // accepted, now RMW_RD
    req_valid = 1'b0;
    @(posedge clk); #1;        // now RMW_WR
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (memWrite !== 1'b0) begin
      n_fail++; $display("FAIL abort_memwrite got %b exp 0", memWrite);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_ready got %b exp 1", req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) saw_resp++;
      @(negedge clk);
    end
    n_tests++;
    if (saw_resp != 0 || mem[32'h300 >> 2] !== 32'hAABBCCDD) begin
      n_fail++;
      $display("FAIL abort_effects got resp=%0d mem=%h exp resp=0 mem=aabbccdd",
               saw_resp, mem[32'h300 >> 2]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] as  [4] = '{32'h400, 32'h404, 32'h408, 32'h40C};
    logic [31:0] vs  [4] = '{32'hA0A0A0A1, 32'hB1B2B3B4, 32'hC0FFEE00, 32'h13579BDF};
    int          acc [4];
    logic [31:0] got [4];
    int idx = 0, nresp = 0, wr_seen = 0, err_seen = 0;
    for (int i = 0; i < 4; i++) poke(as[i], vs[i]);
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got[nresp] = resp_rdata;
        if (resp_err) err_seen++;
        nresp++;
      end
      if (memWrite) wr_seen++;
      if (idx < 4) begin
        req_valid = 1'b1;
        if (req_ready) begin
          req_write = 1'b0; req_funct3 = 3'b010; req_addr = as[idx];
          acc[idx] = c; idx++;
        end else begin
          req_write = 1'b1; req_funct3 = 3'($urandom_range(0, 7));
          req_addr = $urandom; req_wdata = $urandom;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_tests++;
    if (nresp != 4 || idx != 4) begin
      n_fail++; $display("FAIL b2b_count got resp=%0d acc=%0d exp 4/4", nresp, idx);
    end
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (idx == 4 && acc[i] - acc[i-1] != 3) begin
        n_fail++; $display("FAIL b2b_spacing_%0d got %0d exp 3", i, acc[i] - acc[i-1]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i < nresp && got[i] !== vs[i]) begin
        n_fail++; $display("FAIL b2b_data_%0d got %h exp %h", i, got[i], vs[i]);
      end
    end
    n_tests++;
    if (wr_seen != 0 || err_seen != 0) begin
      n_fail++; $display("FAIL b2b_side_effects got wr=%0d err=%0d exp 0/0", wr_seen, err_seen);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_errors();
    test_sub_store();
    test_word_store();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
